mult_stage_pipe: RTL and testbench

- Parametrised successor to the PE multiply stage: NROW parallel multiplier lanes with a configurable pipeline depth and a rdy/ack handshake on both sides.
- Carries each lane's partial sum and the stage sideband control alongside the product, unchanged, with matched latency.
- Adds signed/unsigned operation, a packed dual-half-width mode (dot product of two half-width pairs), whole-pipeline backpressure stall, and a zero-operand statistics counter.
- Sits between the fetch stage (FS) and the sum stage (SS) of each PE column.

---
 rtl/mult_stage_pipe.sv | 143 ++++++++++++++
 tb/tb_mult_stage_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_stage_pipe.sv
// rtl/mult_stage_pipe.sv - NROW-lane multiply stage with LAT-deep rdy/ack pipeline
module mult_stage_pipe #(
   parameter int NROW    = 4,
   parameter int DWD     = 8,
   parameter int PSUMDWD = 24,
   parameter int LAT     = 2,
   parameter int SIDEW   = 8,
   parameter int ZCW     = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_FS_rdy,
   output logic                      o_FS_ack,
   output logic                      o_MS_rdy,
   input  logic                      i_MS_ack,
   input  logic                      i_signed,
   input  logic                      i_packed,
   input  logic [NROW*DWD-1:0]       i_ipix,
   input  logic [NROW*DWD-1:0]       i_wpix,
   input  logic [NROW*PSUMDWD-1:0]   i_psum,
   input  logic [SIDEW-1:0]          i_side,
   output logic [NROW*2*DWD-1:0]     o_prod,
   output logic [NROW*PSUMDWD-1:0]   o_psum,
   output logic [SIDEW-1:0]          o_side,
   input  logic                      i_zclr,
   output logic [ZCW-1:0]            o_zcnt
);

   localparam int PWD = 2 * DWD;
   localparam int HW  = DWD / 2;
   localparam int ZIW = $clog2(NROW + 1);

   if (LAT < 1 || LAT > 4) begin : g_bad_lat
      $fatal(1, "mult_stage_pipe: LAT must be in 1..4");
   end
   if (DWD % 2 != 0) begin : g_bad_dwd
      $fatal(1, "mult_stage_pipe: DWD must be even");
   end

   // Operand extension to product width; s selects two's complement.
   function automatic logic [PWD-1:0] ext_full(input logic [DWD-1:0] x, input logic s);
      return {{DWD{s & x[DWD-1]}}, x};
   endfunction

   function automatic logic [PWD-1:0] ext_half(input logic [HW-1:0] x, input logic s);
      return {{(PWD-HW){s & x[HW-1]}}, x};
   endfunction

   logic                        stall;
   logic                        fs_xfer;
   logic [LAT-1:0]              v_q;
   logic [NROW*PWD-1:0]         prod_q [LAT];
   logic [NROW*PSUMDWD-1:0]     psum_q [LAT];
   logic [SIDEW-1:0]            side_q [LAT];
   logic [NROW*PWD-1:0]         prod_d;
   logic [ZIW-1:0]              zinc_d;
   logic [ZCW-1:0]              zcnt_q;
   logic [ZCW-1:0]              zcnt_d;
   logic [ZCW:0]                zsum;
   logic [DWD-1:0]              lane_a;
   logic [DWD-1:0]              lane_b;
   logic                        lane_z;

   // The whole pipeline freezes only when the output beat is held off.
   assign stall    = v_q[LAT-1] & ~i_MS_ack;
   assign o_FS_ack = ~stall;
   assign fs_xfer  = i_FS_rdy & ~stall;

   // Per-lane product into slot 0 and count of lanes with a zero operand.
   always_comb begin
      prod_d = '0;
      zinc_d = '0;
      lane_a = '0;
      lane_b = '0;
      lane_z = 1'b0;
      for (int r = 0; r < NROW; r++) begin
         lane_a = i_ipix[r*DWD +: DWD];
         lane_b = i_wpix[r*DWD +: DWD];
         if (i_packed) begin
            prod_d[r*PWD +: PWD] =
               ext_half(lane_a[HW-1:0], i_signed) * ext_half(lane_b[HW-1:0], i_signed) +
               ext_half(lane_a[DWD-1:HW], i_signed) * ext_half(lane_b[DWD-1:HW], i_signed);
            lane_z = (~|lane_a[HW-1:0] | ~|lane_b[HW-1:0]) &
                     (~|lane_a[DWD-1:HW] | ~|lane_b[DWD-1:HW]);
         end else begin
            prod_d[r*PWD +: PWD] = ext_full(lane_a, i_signed) * ext_full(lane_b, i_signed);
            lane_z = ~|lane_a | ~|lane_b;
         end
         zinc_d = zinc_d + ZIW'(lane_z);
      end
   end

   // Saturating next value of the zero counter.
   always_comb begin
      zsum   = {1'b0, zcnt_q} + (ZCW+1)'(zinc_d);
      zcnt_d = zsum[ZCW] ? '1 : zsum[ZCW-1:0];
   end

   // Slot valids shift every unstalled cycle; payloads load only behind a valid.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         v_q <= '0;
         for (int k = 0; k < LAT; k++) begin
            prod_q[k] <= '0;
            psum_q[k] <= '0;
            side_q[k] <= '0;
         end
      end else if (!stall) begin
         v_q[0] <= i_FS_rdy;
         if (i_FS_rdy) begin
            prod_q[0] <= prod_d;
            psum_q[0] <= i_psum;
            side_q[0] <= i_side;
         end
         for (int k = 1; k < LAT; k++) begin
            v_q[k] <= v_q[k-1];
            if (v_q[k-1]) begin
               prod_q[k] <= prod_q[k-1];
               psum_q[k] <= psum_q[k-1];
               side_q[k] <= side_q[k-1];
            end
         end
      end
   end

   // Zero counter: clear has priority over a same-cycle increment.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         zcnt_q <= '0;
      end else if (i_zclr) begin
         zcnt_q <= '0;
      end else if (fs_xfer) begin
         zcnt_q <= zcnt_d;
      end
   end

   assign o_MS_rdy = v_q[LAT-1];
   assign o_prod   = prod_q[LAT-1];
   assign o_psum   = psum_q[LAT-1];
   assign o_side   = side_q[LAT-1];
   assign o_zcnt   = zcnt_q;

endmodule

// File: tb/tb_mult_stage_pipe.sv
// tb/tb_mult_stage_pipe.sv - randomized scoreboard bench for mult_stage_pipe
module tb_mult_stage_pipe;

   localparam int NROW    = 4;
   localparam int DWD     = 8;
   localparam int PSUMDWD = 24;
   localparam int LAT     = 2;
   localparam int SIDEW   = 8;
   localparam int ZCW     = 16;
   localparam int PWD     = 2 * DWD;
   localparam int HW      = DWD / 2;
   localparam int ZMAX    = (1 << ZCW) - 1;

   logic                      clk = 1'b0;
   logic                      rst_n, fs_rdy, ms_ack, sgn, pkd, zclr;
   logic [NROW*DWD-1:0]       ipix, wpix;
   logic [NROW*PSUMDWD-1:0]   psum;
   logic [SIDEW-1:0]          side;
   logic                      o_FS_ack, o_MS_rdy;
   logic [NROW*PWD-1:0]       o_prod;
   logic [NROW*PSUMDWD-1:0]   o_psum;
   logic [SIDEW-1:0]          o_side;
   logic [ZCW-1:0]            o_zcnt;

   always #5 clk = ~clk;

   mult_stage_pipe #(
      .NROW(NROW), .DWD(DWD), .PSUMDWD(PSUMDWD), .LAT(LAT), .SIDEW(SIDEW), .ZCW(ZCW)
   ) dut (
      .i_clk(clk), .i_rst(rst_n),
      .i_FS_rdy(fs_rdy), .o_FS_ack(o_FS_ack),
      .o_MS_rdy(o_MS_rdy), .i_MS_ack(ms_ack),
      .i_signed(sgn), .i_packed(pkd),
      .i_ipix(ipix), .i_wpix(wpix), .i_psum(psum), .i_side(side),
      .o_prod(o_prod), .o_psum(o_psum), .o_side(o_side),
      .i_zclr(zclr), .o_zcnt(o_zcnt)
   );

   typedef struct {
      logic [NROW*PWD-1:0]     prod;
      logic [NROW*PSUMDWD-1:0] psum;
      logic [SIDEW-1:0]        side;
   } beat_t;

   beat_t               q[$];
   int                  n_checks = 0;
   int                  n_errors = 0;
   int                  n_pop = 0;
   int                  zc_m = 0;
   logic                prev_stall = 1'b0;
   logic [NROW*PWD-1:0] prev_prod = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int val_full(input logic [DWD-1:0] x, input logic s);
      if (s) return $signed(x);
      return x;
   endfunction

   function automatic int val_half(input logic [HW-1:0] x, input logic s);
      if (s) return $signed(x);
      return x;
   endfunction

   function automatic logic [PWD-1:0] ref_lane(input logic [DWD-1:0] a, input logic [DWD-1:0] b,
                                               input logic s, input logic p);
      int r;
      if (p)
         r = val_half(a[HW-1:0], s) * val_half(b[HW-1:0], s) +
             val_half(a[DWD-1:HW], s) * val_half(b[DWD-1:HW], s);
      else
         r = val_full(a, s) * val_full(b, s);
      return r[PWD-1:0];
   endfunction

   function automatic int ref_zero(input logic [DWD-1:0] a, input logic [DWD-1:0] b, input logic p);
      if (p)
         return ((a[HW-1:0] == 0 || b[HW-1:0] == 0) && (a[DWD-1:HW] == 0 || b[DWD-1:HW] == 0)) ? 1 : 0;
      return (a == 0 || b == 0) ? 1 : 0;
   endfunction

   // One clock: scoreboard bookkeeping at the falling edge, counter check after the rising edge.
   task automatic tick();
      beat_t e;
      int    zinc;
      @(negedge clk);
      check("fs_ack", o_FS_ack, !(o_MS_rdy && !ms_ack));
      if (rst_n && prev_stall) check("hold_prod", o_prod, prev_prod);
      if (o_MS_rdy && ms_ack) begin
         check("beat_expected", q.size() != 0, 1'b1);
         if (q.size() != 0) begin
            e = q.pop_front();
            n_pop++;
            check("prod", o_prod, e.prod);
            check("psum", o_psum, e.psum);
            check("side", o_side, e.side);
         end
      end
      prev_stall = rst_n && o_MS_rdy && !ms_ack;
      prev_prod  = o_prod;
      zinc = 0;
      for (int r = 0; r < NROW; r++) begin
         e.prod[r*PWD +: PWD] = ref_lane(ipix[r*DWD +: DWD], wpix[r*DWD +: DWD], sgn, pkd);
         zinc += ref_zero(ipix[r*DWD +: DWD], wpix[r*DWD +: DWD], pkd);
      end
      e.psum = psum;
      e.side = side;
      if (!rst_n) zc_m = 0;
      else if (zclr) zc_m = 0;
      else if (fs_rdy && o_FS_ack) zc_m = (zc_m + zinc > ZMAX) ? ZMAX : zc_m + zinc;
      if (rst_n && fs_rdy && o_FS_ack) q.push_back(e);
      @(posedge clk);
      #1;
      check("zcnt", o_zcnt, zc_m[ZCW-1:0]);
   endtask

   task automatic one_beat(input string tag, input logic [DWD-1:0] a, input logic [DWD-1:0] b,
                           input logic s, input logic p, input logic [PWD-1:0] exp);
      logic found;
      ipix[DWD-1:0] = a;
      wpix[DWD-1:0] = b;
      sgn = s; pkd = p; fs_rdy = 1'b1; ms_ack = 1'b1;
      tick();
      fs_rdy = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         if (o_MS_rdy) found = 1'b1;
         else tick();
      end
      check({tag, "_seen"}, found, 1'b1);
      if (found) check(tag, o_prod[PWD-1:0], exp);
      tick();
   endtask

   task automatic rand_lanes();
      for (int r = 0; r < NROW; r++) begin
         ipix[r*DWD +: DWD] = ($urandom % 4 == 0) ? '0 : DWD'($urandom);
         wpix[r*DWD +: DWD] = ($urandom % 4 == 0) ? '0 : DWD'($urandom);
         psum[r*PSUMDWD +: PSUMDWD] = PSUMDWD'($urandom);
      end
      side = SIDEW'($urandom);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst_n = 1'b0; fs_rdy = 1'b0; ms_ack = 1'b0; sgn = 1'b0; pkd = 1'b0; zclr = 1'b0;
      ipix = '0; wpix = '0; psum = '0; side = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ms_rdy", o_MS_rdy, 1'b0);
      check("rst_prod", o_prod, '0);
      check("rst_psum", o_psum, '0);
      check("rst_side", o_side, '0);
      check("rst_zcnt", o_zcnt, '0);
      check("rst_fs_ack", o_FS_ack, 1'b1);
      rst_n = 1'b1;
      tick();

      // Latency: one beat, visible for exactly one cycle LAT cycles after acceptance.
      ipix = {8'd7, 8'd9, 8'd11, 8'd3};
      wpix = {8'd2, 8'd4, 8'd6, 8'd5};
      psum = {24'd1, 24'd2, 24'd3, 24'd100};
      side = 8'h5A;
      ms_ack = 1'b1; fs_rdy = 1'b1;
      tick();
      fs_rdy = 1'b0;
      check("lat_early", o_MS_rdy, 1'b0);
      check("lat_ack1", o_FS_ack, 1'b1);
      tick();
      check("lat_rdy", o_MS_rdy, 1'b1);
      check("lat_prod", o_prod[PWD-1:0], 16'd15);
      check("lat_psum", o_psum[PSUMDWD-1:0], 24'd100);
      check("lat_side", o_side, 8'h5A);
      check("lat_ack2", o_FS_ack, 1'b1);
      tick();
      check("lat_once", o_MS_rdy, 1'b0);

      // Signed / unsigned / packed corner operands.
      one_beat("s_neg", 8'hFF, 8'h80, 1'b1, 1'b0, 16'd128);
      one_beat("u_big", 8'hFF, 8'h80, 1'b0, 1'b0, 16'd32640);
      one_beat("p_sgn", 8'h2F, 8'h3E, 1'b1, 1'b1, 16'd8);
      one_beat("p_uns", 8'h2F, 8'h3E, 1'b0, 1'b1, 16'd216);

      // Backpressure: beats 1..6 with the output held off for cycles 3..7.
      sgn = 1'b0; pkd = 1'b0;
      n_pop = 0;
      k = 1;
      for (int c = 1; c <= 20; c++) begin
         ms_ack = !(c >= 3 && c <= 7);
         fs_rdy = (k <= 6);
         ipix[DWD-1:0] = DWD'(k);
         wpix[DWD-1:0] = 8'd1;
         psum[PSUMDWD-1:0] = PSUMDWD'(k);
         tick();
         if (k <= 6 && prev_stall == 1'b0 && q.size() != 0 && q[q.size()-1].psum[PSUMDWD-1:0] == PSUMDWD'(k))
            k++;
      end
      check("bp_count", n_pop, 6);
      check("bp_all_in", k, 7);

      // Zero counter: three beats of two zero lanes, then clear wins over a fourth.
      fs_rdy = 1'b0; ms_ack = 1'b1;
      zclr = 1'b1; tick(); zclr = 1'b0;
      ipix = {8'd1, 8'd2, 8'd0, 8'd3};
      wpix = {8'd4, 8'd0, 8'd5, 8'd6};
      fs_rdy = 1'b1;
      repeat (3) tick();
      check("zc_six", o_zcnt, 16'd6);
      zclr = 1'b1; tick(); zclr = 1'b0;
      check("zc_clr", o_zcnt, 16'd0);

      // Saturation: fill to 0xFFFC with all-zero lanes, then two-zero-lane beats.
      ipix = '0;
      repeat (16383) tick();
      check("zc_fffc", o_zcnt, 16'hFFFC);
      ipix = {8'd1, 8'd2, 8'd0, 8'd3};
      tick();
      check("zc_fffe", o_zcnt, 16'hFFFE);
      tick();
      check("zc_sat", o_zcnt, 16'hFFFF);
      tick();
      check("zc_hold", o_zcnt, 16'hFFFF);
      fs_rdy = 1'b0;
      repeat (LAT + 2) tick();

      // Randomized traffic with random backpressure, modes and clears.
      for (int c = 0; c < 3000; c++) begin
         rand_lanes();
         fs_rdy = ($urandom % 4 != 0);
         ms_ack = ($urandom % 4 != 0);
         sgn    = 1'($urandom);
         pkd    = 1'($urandom);
         zclr   = ($urandom % 32 == 0);
         tick();
      end
      fs_rdy = 1'b0; ms_ack = 1'b1; zclr = 1'b0;
      repeat (LAT + 2) tick();
      check("drain_empty", q.size(), 0);

      // Reset with two beats in flight.
      ms_ack = 1'b0; fs_rdy = 1'b1;
      rand_lanes(); tick();
      rand_lanes(); tick();
      fs_rdy = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_rdy", o_MS_rdy, 1'b0);
      check("mid_rst_prod", o_prod, '0);
      check("mid_rst_ack", o_FS_ack, 1'b1);
      check("mid_rst_zcnt", o_zcnt, '0);
      q.delete();
      zc_m = 0;
      prev_stall = 1'b0;
      tick();
      rst_n = 1'b1; ms_ack = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("post_rst_idle", o_MS_rdy, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
